// File: rtl/red_seq_reducer.sv
// Multi-cycle lane-reduction unit: sums every LANE_W lane of a and b, one lane pair per cycle.
// Optional RED_UNSIGNED_EN adds in_unsigned to select zero- instead of sign-extension.
module red_seq_reducer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
`ifdef RED_UNSIGNED_EN
    input  logic              in_unsigned,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              busy
);

    localparam int unsigned LANES = DATA_W / LANE_W;
    localparam int unsigned ACC_W = LANE_W + $clog2(2 * LANES) + 1;
    localparam int unsigned CNT_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_nxt;
    logic [CNT_W-1:0]    lane_cnt;
    logic                uns_r;
    logic [LANE_W-1:0]   lanes_a [LANES];
    logic [LANE_W-1:0]   lanes_b [LANES];

    function automatic logic [ACC_W-1:0] ext_lane(input logic [LANE_W-1:0] x, input logic u);
        if (u) return ACC_W'(x);
        else   return ACC_W'($signed(x));
    endfunction

    function automatic logic [DATA_W-1:0] ext_sum(input logic [ACC_W-1:0] x, input logic u);
        if (u) return DATA_W'(x);
        else   return DATA_W'($signed(x));
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lanes
        assign lanes_a[i] = a_r[i*LANE_W +: LANE_W];
        assign lanes_b[i] = b_r[i*LANE_W +: LANE_W];
    end

`ifndef RED_UNSIGNED_EN
    assign uns_r = 1'b0;
`endif

    // One lane pair folded into the running total per ACC cycle
    always_comb begin
        acc_nxt = acc + ext_lane(lanes_a[lane_cnt], uns_r) + ext_lane(lanes_b[lane_cnt], uns_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            lane_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
`ifdef RED_UNSIGNED_EN
            uns_r     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
`ifdef RED_UNSIGNED_EN
                        uns_r    <= in_unsigned;
`endif
                        acc      <= '0;
                        lane_cnt <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc      <= acc_nxt;
                    lane_cnt <= lane_cnt + CNT_W'(1);
                    // Result is registered as the last lane pair is added
                    if (lane_cnt == CNT_W'(LANES - 1)) begin
                        sum       <= ext_sum(acc_nxt, uns_r);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_red_seq_reducer.sv
// Self-checking bench for red_seq_reducer: 16/8 instance checked every cycle against a
// handshake-level model, plus a 16/4 instance with directed checks.
module tb_red_seq_reducer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        uns_i = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [15:0] sum;

    logic        v4 = 1'b0;
    logic        or4 = 1'b1;
    logic [15:0] a4 = '0;
    logic [15:0] b4 = '0;
    logic        uns4 = 1'b0;
    logic        rdy4, ov4, busy4;
    logic [15:0] s4;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    red_seq_reducer #(.DATA_W(16), .LANE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i),
`ifdef RED_UNSIGNED_EN
        .in_unsigned(uns_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
    );

    red_seq_reducer #(.DATA_W(16), .LANE_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .a(a4), .b(b4),
`ifdef RED_UNSIGNED_EN
        .in_unsigned(uns4),
`endif
        .out_valid(ov4), .out_ready(or4), .sum(s4), .busy(busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_val(input logic [15:0] x, input int i, input int lw, input bit u);
        int v;
        v = int'(x >> (i * lw)) & ((1 << lw) - 1);
        if (!u && v >= (1 << (lw - 1))) v -= (1 << lw);
        return v;
    endfunction

    // Reference: plain integer sum of all lanes, truncated to the 16-bit result
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input int lw, input bit u);
        int tot;
        tot = 0;
        for (int i = 0; i < 16 / lw; i++) tot += lane_val(x, i, lw, u) + lane_val(y, i, lw, u);
        return 16'(tot);
    endfunction

    // Handshake-level expectation: k counts edges since acceptance, result shows at k == 2
    bit          pend = 1'b0;
    int          k = 0;
    logic [15:0] exp_sum = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else if (pend) begin
            if (k >= 2 && out_ready) pend = 1'b0;
            else k++;
        end else if (in_valid) begin
            pend    = 1'b1;
            k       = 0;
            exp_sum = model(a_i, b_i, 8, uns_i);
        end
    end

    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(!pend));
        check("busy", 32'(busy), 32'(pend));
        check("out_valid", 32'(out_valid), 32'(pend && k >= 2));
        if (pend && k >= 2) check("sum", 32'(sum), 32'(exp_sum));
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic u,
                         input logic [15:0] exp_lit, input int hold, input string tag);
        int lat;
        bit seen;
        in_valid = 1'b1; a_i = a; b_i = b; uns_i = u; out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin seen = 1'b1; break; end
        end
        check({tag, "_accept"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a_i = ~a; b_i = b ^ 16'h5A5A;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_sum"}, 32'(sum), 32'(exp_lit));
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_bp_sum"}, 32'(sum), 32'(exp_lit));
            check({tag, "_bp_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic u,
                          input logic [15:0] exp, input string tag);
        int lat;
        v4 = 1'b1; a4 = a; b4 = b; uns4 = u;
        @(negedge clk);
        check({tag, "_ready"}, 32'(rdy4), 32'd1);
        @(posedge clk); #1;
        v4 = 1'b0; a4 = 16'h0; b4 = 16'h0;
        lat = 1;
        while (!ov4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_sum"}, 32'(s4), 32'(exp));
        check({tag, "_busy"}, 32'(busy4), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done"}, 32'(ov4), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        check("pin_small", 32'(model(16'h0102, 16'h0304, 8, 1'b0)), 32'h000A);
        check("pin_neg", 32'(model(16'h8080, 16'h8080, 8, 1'b0)), 32'hFE00);
        check("pin_l4", 32'(model(16'hFFFF, 16'h0000, 4, 1'b0)), 32'hFFFC);
        check("pin_uns", 32'(model(16'hFFFF, 16'hFFFF, 8, 1'b1)), 32'h03FC);

        @(posedge clk); #1;
        do_op(16'h0102, 16'h0304, 1'b0, 16'h000A, 0, "basic");
        do_op(16'h7F7F, 16'h7F7F, 1'b0, 16'h01FC, 0, "max_pos");
        do_op(16'h8080, 16'h8080, 1'b0, 16'hFE00, 0, "max_neg");
        do_op(16'h1234, 16'hFEDC, 1'b0, 16'h0020, 5, "backpressure");

        // Back-to-back operations with the consumer always ready
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_i = 16'($urandom); b_i = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;

        // Abandon an operation mid-accumulation
        in_valid = 1'b1; a_i = 16'h1111; b_i = 16'h2222;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_op(16'h0001, 16'h0000, 1'b0, 16'h0001, 0, "post_rst");

`ifdef RED_UNSIGNED_EN
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'h03FC, 0, "uns_on");
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFC, 0, "uns_off");
        do_op4(16'hFFFF, 16'hFFFF, 1'b1, model(16'hFFFF, 16'hFFFF, 4, 1'b1), "l4_uns");
        uns_i = 1'b0;
`endif

        do_op4(16'hFFFF, 16'h0000, 1'b0, 16'hFFFC, "l4_neg");
        do_op4(16'h1234, 16'h8765, 1'b0, model(16'h1234, 16'h8765, 4, 1'b0), "l4_mix");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
